cdt_count_down: RTL and testbench

CDT_COUNT_DOWN -- requirements
Module: cdt_count_down

---
 rtl/cdt_count_down_pkg.sv | 14 +
 rtl/cdt_count_down_if.sv | 28 ++
 rtl/cdt_sec_tick.sv | 27 ++
 rtl/cdt_count_down.sv | 93 +++++++++
 tb/tb_cdt_count_down.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/cdt_count_down_pkg.sv
// cdt_count_down_pkg: shared FSM state encoding, time limits and saturation helper for the countdown timer
package cdt_count_down_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    ALARM = 2'd3
  } state_t;
  localparam logic [7:0] MAX_MIN = 8'd99;
  localparam logic [7:0] MAX_SEC = 8'd59;
  function automatic logic [7:0] sat(input logic [7:0] v, input logic [7:0] lim);
    return v > lim ? lim : v;
  endfunction
endpackage

// File: rtl/cdt_count_down_if.sv
// cdt_count_down_if: control/status bundle of the countdown timer
//   controls : load, load_min[7:0], load_sec[7:0], start, pause, clear, alarm_ack
//   status   : minutes[7:0], seconds[7:0], sec_minus_one, expired, alarm, state
//   master drives controls and reads status; slave (the timer) does the opposite
interface cdt_count_down_if;
  import cdt_count_down_pkg::*;
  logic       load;
  logic [7:0] load_min;
  logic [7:0] load_sec;
  logic       start;
  logic       pause;
  logic       clear;
  logic       alarm_ack;
  logic [7:0] minutes;
  logic [7:0] seconds;
  logic       sec_minus_one;
  logic       expired;
  logic       alarm;
  state_t     state;
  modport master (
    output load, load_min, load_sec, start, pause, clear, alarm_ack,
    input  minutes, seconds, sec_minus_one, expired, alarm, state
  );
  modport slave (
    input  load, load_min, load_sec, start, pause, clear, alarm_ack,
    output minutes, seconds, sec_minus_one, expired, alarm, state
  );
endinterface

// File: rtl/cdt_sec_tick.sv
// cdt_sec_tick: one-second prescaler counting 0..CYCLES-1 and flagging the wrap cycle
//   CLK, rst_n : clock, asynchronous active-low reset
//   en         : advance the count this cycle
//   hold       : freeze the count this cycle (overrides en)
//   zero       : force the count to 0 (overrides hold and en)
//   tick       : combinational, high in the cycle the count wraps
module cdt_sec_tick #(
  parameter int CYCLES = 1000
) (
  input  logic CLK,
  input  logic rst_n,
  input  logic en,
  input  logic hold,
  input  logic zero,
  output logic tick
);
  localparam int W = CYCLES > 1 ? $clog2(CYCLES) : 1;
  logic [W-1:0] cnt_q;
  logic         wrap;
  assign wrap = cnt_q == W'(CYCLES - 1);
  assign tick = en && !hold && !zero && wrap;
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else if (zero) cnt_q <= '0;
    else if (en && !hold) cnt_q <= wrap ? '0 : cnt_q + W'(1);
  end
endmodule

// File: rtl/cdt_count_down.sv
// cdt_count_down: mm:ss countdown timer with pause/resume and self-clearing alarm
//   CLK, rst_n : clock (CYCLES_PER_SEC per second), asynchronous active-low reset
//   bus        : slave side of cdt_count_down_if (controls in, time/state/pulses out)
// Input priority is clear > load > pause > start; an input only blocks lower ones
// in states where it actually takes effect (e.g. load is inert in RUN).
module cdt_count_down
  import cdt_count_down_pkg::*;
#(
  parameter int CYCLES_PER_SEC = 1000,
  parameter int ALARM_SEC      = 10
) (
  input logic             CLK,
  input logic             rst_n,
  cdt_count_down_if.slave bus
);
  localparam int AW = $clog2(ALARM_SEC + 1);
  state_t        state_q;
  logic [7:0]    min_q;
  logic [7:0]    sec_q;
  logic [AW-1:0] asec_q;
  logic          expired_q;
  logic          alarm_q;
  logic in_run, in_alarm, idle_or_pause, zero_time;
  logic do_load, do_pause, do_start, tick, dec, last, alarm_end, pre_zero;
  assign in_run        = state_q == RUN;
  assign in_alarm      = state_q == ALARM;
  assign idle_or_pause = state_q == IDLE || state_q == PAUSE;
  assign zero_time     = min_q == '0 && sec_q == '0;
  assign do_load       = !bus.clear && bus.load && idle_or_pause;
  assign do_pause      = !bus.clear && bus.pause && in_run;
  // A zero time can never run, which also keeps RUN from underflowing.
  assign do_start      = !bus.clear && !do_load && bus.start && idle_or_pause && !zero_time;
  assign pre_zero      = bus.clear || do_load || (do_start && state_q == IDLE) || (in_alarm && bus.alarm_ack);
  cdt_sec_tick #(.CYCLES(CYCLES_PER_SEC)) u_tick (
    .CLK  (CLK),
    .rst_n(rst_n),
    .en   (in_run || in_alarm),
    .hold (do_pause),
    .zero (pre_zero),
    .tick (tick)
  );
  // In ALARM the same prescaler paces the alarm-second counter.
  assign dec       = tick && in_run;
  assign last      = min_q == '0 && sec_q == 8'd1;
  assign alarm_end = in_alarm && (bus.alarm_ack || (tick && asec_q == AW'(ALARM_SEC - 1)));
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      min_q     <= '0;
      sec_q     <= '0;
      asec_q    <= '0;
      expired_q <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      expired_q <= 1'b0;
      if (bus.clear) begin
        state_q <= IDLE;
        min_q   <= '0;
        sec_q   <= '0;
        asec_q  <= '0;
        alarm_q <= 1'b0;
      end else if (do_load) begin
        min_q <= sat(bus.load_min, MAX_MIN);
        sec_q <= sat(bus.load_sec, MAX_SEC);
      end else if (do_pause) begin
        state_q <= PAUSE;
      end else if (do_start) begin
        state_q <= RUN;
      end else if (dec) begin
        min_q <= sec_q == '0 ? min_q - 8'd1 : min_q;
        sec_q <= sec_q == '0 ? MAX_SEC : sec_q - 8'd1;
        if (last) begin
          state_q   <= ALARM;
          alarm_q   <= 1'b1;
          expired_q <= 1'b1;
          asec_q    <= '0;
        end
      end else if (alarm_end) begin
        state_q <= IDLE;
        alarm_q <= 1'b0;
        asec_q  <= '0;
      end else if (in_alarm && tick) begin
        asec_q <= asec_q + AW'(1);
      end
    end
  end
  assign bus.minutes       = min_q;
  assign bus.seconds       = sec_q;
  assign bus.sec_minus_one = dec;
  assign bus.expired       = expired_q;
  assign bus.alarm         = alarm_q;
  assign bus.state         = state_q;
endmodule

// File: tb/tb_cdt_count_down.sv
// tb_cdt_count_down: vector table, corner sequences and random run against a seconds-level model
module tb_cdt_count_down;
  localparam int CPS = 4;
  localparam int ASEC = 3;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_ALARM = 3;
  logic CLK = 1'b0;
  logic rst_n;
  int n_pass = 0;
  int n_tot = 0;
  int smo_s;
  int m_st, m_rem, m_pc, m_ac, m_exp;
  typedef struct {int ld, st, ps, cl, ack, lm, ls, es, em, esec, esmo, eexp, ealm;} vec_t;
  vec_t vt[$];
  cdt_count_down_if b();
  cdt_count_down #(.CYCLES_PER_SEC(CPS), .ALARM_SEC(ASEC)) dut (.CLK(CLK), .rst_n(rst_n), .bus(b.slave));
  always #5 CLK = ~CLK;
  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask
  task automatic chk_out(input string nm, input int es, input int em, input int esec, input int eexp, input int ealm);
    chk({nm, "_state"}, int'(b.state), es);
    chk({nm, "_min"}, int'(b.minutes), em);
    chk({nm, "_sec"}, int'(b.seconds), esec);
    chk({nm, "_expired"}, int'(b.expired), eexp);
    chk({nm, "_alarm"}, int'(b.alarm), ealm);
  endtask
  task automatic drive(input int ld, input int st, input int ps, input int cl, input int ack, input int lm, input int ls);
    b.load = ld != 0;
    b.start = st != 0;
    b.pause = ps != 0;
    b.clear = cl != 0;
    b.alarm_ack = ack != 0;
    b.load_min = 8'(lm);
    b.load_sec = 8'(ls);
  endtask
  task automatic cyc(input int ld, input int st, input int ps, input int cl, input int ack, input int lm, input int ls);
    drive(ld, st, ps, cl, ack, lm, ls);
    #1;
    smo_s = int'(b.sec_minus_one);
    @(posedge CLK);
    #1;
  endtask
  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, 0, 0, 0, 0);
  endtask
  // Time kept as total remaining seconds; ALARM as elapsed cycles.
  task automatic model_step(input int ld, input int st, input int ps, input int cl, input int ack, input int lm, input int ls, output int smo);
    smo = 0;
    m_exp = 0;
    if (cl != 0) begin
      m_st = S_IDLE; m_rem = 0; m_pc = 0; m_ac = 0;
    end else if (m_st == S_IDLE || m_st == S_PAUSE) begin
      if (ld != 0) begin
        m_rem = (lm > 99 ? 99 : lm) * 60 + (ls > 59 ? 59 : ls);
        m_pc = 0;
      end else if (st != 0 && m_rem > 0) begin
        if (m_st == S_IDLE) m_pc = 0;
        m_st = S_RUN;
      end
    end else if (m_st == S_RUN) begin
      if (ps != 0) m_st = S_PAUSE;
      else if (m_pc == CPS - 1) begin
        smo = 1;
        m_pc = 0;
        m_rem = m_rem - 1;
        if (m_rem == 0) begin m_st = S_ALARM; m_exp = 1; m_ac = 0; end
      end else m_pc = m_pc + 1;
    end else begin
      m_ac = m_ac + 1;
      if (ack != 0 || m_ac == ASEC * CPS) m_st = S_IDLE;
    end
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    int n, lim;
    int ld, st, ps, cl, ack, lm, ls, esmo;
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    #1 rst_n = 1'b0;
    #1;
    chk_out("reset", S_IDLE, 0, 0, 0, 0);
    chk("reset_smo", int'(b.sec_minus_one), 0);
    repeat (2) @(posedge CLK);
    #1 rst_n = 1'b1;
    vt.push_back('{1, 0, 0, 0, 0, 0, 2, S_IDLE, 0, 2, 0, 0, 0});
    vt.push_back('{0, 1, 0, 0, 0, 0, 0, S_RUN, 0, 2, 0, 0, 0});
    repeat (3) vt.push_back('{0, 0, 0, 0, 0, 0, 0, S_RUN, 0, 2, 0, 0, 0});
    vt.push_back('{0, 0, 0, 0, 0, 0, 0, S_RUN, 0, 1, 1, 0, 0});
    repeat (3) vt.push_back('{0, 0, 0, 0, 0, 0, 0, S_RUN, 0, 1, 0, 0, 0});
    vt.push_back('{0, 0, 0, 0, 0, 0, 0, S_ALARM, 0, 0, 1, 1, 1});
    vt.push_back('{0, 0, 0, 0, 0, 0, 0, S_ALARM, 0, 0, 0, 0, 1});
    vt.push_back('{1, 1, 1, 0, 0, 5, 5, S_ALARM, 0, 0, 0, 0, 1});
    vt.push_back('{0, 0, 0, 0, 1, 0, 0, S_IDLE, 0, 0, 0, 0, 0});
    vt.push_back('{0, 1, 0, 0, 0, 0, 0, S_IDLE, 0, 0, 0, 0, 0});
    vt.push_back('{0, 0, 0, 0, 1, 0, 0, S_IDLE, 0, 0, 0, 0, 0});
    vt.push_back('{1, 0, 0, 0, 0, 1, 0, S_IDLE, 1, 0, 0, 0, 0});
    vt.push_back('{0, 1, 0, 0, 0, 0, 0, S_RUN, 1, 0, 0, 0, 0});
    repeat (3) vt.push_back('{0, 0, 0, 0, 0, 0, 0, S_RUN, 1, 0, 0, 0, 0});
    vt.push_back('{0, 0, 0, 0, 0, 0, 0, S_RUN, 0, 59, 1, 0, 0});
    vt.push_back('{1, 0, 0, 0, 0, 150, 75, S_RUN, 0, 59, 0, 0, 0});
    vt.push_back('{0, 0, 1, 0, 0, 0, 0, S_PAUSE, 0, 59, 0, 0, 0});
    vt.push_back('{1, 0, 0, 0, 0, 150, 75, S_PAUSE, 99, 59, 0, 0, 0});
    vt.push_back('{0, 0, 0, 1, 0, 0, 0, S_IDLE, 0, 0, 0, 0, 0});
    for (int i = 0; i < vt.size(); i++) begin
      cyc(vt[i].ld, vt[i].st, vt[i].ps, vt[i].cl, vt[i].ack, vt[i].lm, vt[i].ls);
      chk($sformatf("v%0d_smo", i), smo_s, vt[i].esmo);
      chk_out($sformatf("v%0d", i), vt[i].es, vt[i].em, vt[i].esec, vt[i].eexp, vt[i].ealm);
    end
    cyc(0, 0, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 10);
    cyc(0, 1, 0, 0, 0, 0, 0);
    idle(2);
    cyc(0, 0, 1, 0, 0, 0, 0);
    chk("pause_enter_smo", smo_s, 0);
    idle(9);
    chk_out("paused", S_PAUSE, 0, 10, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("resume_state", int'(b.state), S_RUN);
    idle(1);
    chk("resume_early_smo", smo_s, 0);
    chk("resume_early_sec", int'(b.seconds), 10);
    idle(1);
    chk("resume_tick_smo", smo_s, 1);
    chk("resume_tick_sec", int'(b.seconds), 9);
    cyc(0, 0, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 0, 0, 0);
    idle(4);
    chk_out("noack_entry", S_ALARM, 0, 0, 1, 1);
    n = 1;
    lim = 0;
    while (lim < 20) begin
      idle(1);
      lim++;
      if (int'(b.state) == S_ALARM) n++;
      else break;
    end
    chk("noack_alarm_cycles", n, ASEC * CPS);
    chk_out("noack_exit", S_IDLE, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 0, 0, 0);
    idle(4);
    idle(2);
    chk_out("ack_cycle3", S_ALARM, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1, 0, 0);
    chk_out("ack_exit", S_IDLE, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 5);
    cyc(0, 1, 0, 0, 0, 0, 0);
    idle(1);
    cyc(1, 0, 0, 1, 0, 7, 7);
    chk_out("clear_load", S_IDLE, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk_out("start_zero", S_IDLE, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 3);
    cyc(0, 1, 0, 0, 0, 0, 0);
    idle(2);
    chk("midrun_state", int'(b.state), S_RUN);
    #2 rst_n = 1'b0;
    #1;
    chk_out("async_rst", S_IDLE, 0, 0, 0, 0);
    chk("async_rst_smo", int'(b.sec_minus_one), 0);
    @(posedge CLK);
    #1 rst_n = 1'b1;
    m_st = S_IDLE; m_rem = 0; m_pc = 0; m_ac = 0; m_exp = 0;
    for (int i = 0; i < 4000; i++) begin
      cl = $urandom_range(0, 99) < 2 ? 1 : 0;
      ld = $urandom_range(0, 99) < 10 ? 1 : 0;
      ps = $urandom_range(0, 99) < 6 ? 1 : 0;
      st = $urandom_range(0, 99) < 20 ? 1 : 0;
      ack = $urandom_range(0, 99) < 12 ? 1 : 0;
      lm = $urandom_range(0, 9) == 0 ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 1));
      ls = $urandom_range(0, 9) == 0 ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 8));
      model_step(ld, st, ps, cl, ack, lm, ls, esmo);
      cyc(ld, st, ps, cl, ack, lm, ls);
      chk("rnd_smo", smo_s, esmo);
      chk_out("rnd", m_st, m_rem / 60, m_rem % 60, m_exp, m_st == S_ALARM ? 1 : 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
